imul_var_lat_param: RTL and testbench

Parametrised variable-latency iterative integer multiplier, the successor to the fixed 32-bit shift-add multiplier in the imul subsystem. It takes one operand pair per transaction over a val/rdy input stream and returns one NBITS-bit result over a val/rdy output stream. New capabilities:
- Generic operand width.
- Signed or unsigned mode per transaction.
- Selection of the high or low half of the 2·NBITS product.
- Bounded zero-skipping of up to MAX_SKIP bits per cycle.

---
 rtl/imul_pkg.sv | 37 +++
 rtl/imul_tz_cnt.sv | 25 ++
 rtl/imul_var_lat_param.sv | 128 ++++++++++++
 tb/tb_imul_var_lat_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imul_pkg.sv
// Shared types and message field positions for the iterative multiplier family.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Request message layout: {signed, hi, a, b}
    function automatic int SIGNED_BIT(input int nbits);
        return 2 * nbits + 1;
    endfunction

    function automatic int HI_BIT(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int A_MSB(input int nbits);
        return 2 * nbits - 1;
    endfunction

    function automatic int A_LSB(input int nbits);
        return nbits;
    endfunction

    function automatic int B_MSB(input int nbits);
        return nbits - 1;
    endfunction

    function automatic int B_LSB(input int nbits);
        return 0 * nbits;
    endfunction

endpackage

// File: rtl/imul_tz_cnt.sv
// Trailing-zero count of the multiplier register, saturated at MAX_SKIP.
// Latency: combinational.
// Backpressure: not applicable.
module imul_tz_cnt #(
    parameter int NBITS    = 32,
    parameter int MAX_SKIP = 8,
    localparam int CW      = $clog2(MAX_SKIP + 1)
) (
    input  logic [NBITS-1:0] b,
    output logic [CW-1:0]    cnt
);

    // Lowest set bit within the first MAX_SKIP positions wins; none set saturates
    always_comb begin
        cnt = CW'(MAX_SKIP);
        if (b != '0) begin
            for (int i = MAX_SKIP - 1; i >= 0; i--) begin
                if (b[i]) begin
                    cnt = CW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/imul_var_lat_param.sv
// Iterative NBITS x NBITS multiplier: signed/unsigned, hi/lo half, zero-skipping shift-add.
// Latency: 2 + (add steps + skip steps) cycles from accept to result valid; N+2 worst case.
// Backpressure: one transaction in flight; result held in DONE until ostream_rdy, no accept meanwhile.
module imul_var_lat_param #(
    parameter int NBITS    = 32,
    parameter int MAX_SKIP = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [2*NBITS+1:0]   istream_msg,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [NBITS-1:0]     ostream_msg
);
    import imul_pkg::*;

    localparam int CW    = $clog2(MAX_SKIP + 1);
    localparam int S_BIT = SIGNED_BIT(NBITS);
    localparam int H_BIT = HI_BIT(NBITS);
    localparam int AM    = A_MSB(NBITS);
    localparam int AL    = A_LSB(NBITS);
    localparam int BM    = B_MSB(NBITS);
    localparam int BL    = B_LSB(NBITS);

    state_t               state;
    state_t               state_nxt;
    logic [2*NBITS-1:0]   acc;
    logic [2*NBITS-1:0]   acc_a;
    logic [NBITS-1:0]     b_reg;
    logic [NBITS-1:0]     result;
    logic                 neg;
    logic                 hi;
    logic [CW-1:0]        skip;

    logic                 sgn_in;
    logic                 hi_in;
    logic [NBITS-1:0]     a_in;
    logic [NBITS-1:0]     b_in;
    logic [NBITS-1:0]     a_mag;
    logic [NBITS-1:0]     b_mag;
    logic [2*NBITS-1:0]   prod_fix;

    assign sgn_in = istream_msg[S_BIT];
    assign hi_in  = istream_msg[H_BIT];
    assign a_in   = istream_msg[AM:AL];
    assign b_in   = istream_msg[BM:BL];

    // Magnitudes; the most negative value maps onto its unsigned twin, which fits
    assign a_mag    = (sgn_in && a_in[NBITS-1]) ? -a_in : a_in;
    assign b_mag    = (sgn_in && b_in[NBITS-1]) ? -b_in : b_in;
    assign prod_fix = neg ? -acc : acc;

    imul_tz_cnt #(
        .NBITS    (NBITS),
        .MAX_SKIP (MAX_SKIP)
    ) u_tz_cnt (
        .b   (b_reg),
        .cnt (skip)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept, iterate until multiplier is exhausted, wait for consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (istream_val) state_nxt = CALC;
            CALC:    if (b_reg == '0) state_nxt = DONE;
            DONE:    if (ostream_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        istream_rdy = (state == IDLE);
        ostream_val = (state == DONE);
    end

    // Operand, accumulator and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            acc_a  <= '0;
            b_reg  <= '0;
            result <= '0;
            neg    <= 1'b0;
            hi     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val && istream_rdy) begin
                        neg   <= sgn_in & (a_in[NBITS-1] ^ b_in[NBITS-1]);
                        hi    <= hi_in;
                        acc_a <= {{NBITS{1'b0}}, a_mag};
                        b_reg <= b_mag;
                        acc   <= '0;
                    end
                end
                CALC: begin
                    if (b_reg == '0) begin
                        result <= hi ? prod_fix[2*NBITS-1:NBITS] : prod_fix[NBITS-1:0];
                    end else if (b_reg[0]) begin
                        acc   <= acc + acc_a;
                        acc_a <= acc_a << 1;
                        b_reg <= b_reg >> 1;
                    end else begin
                        acc_a <= acc_a << skip;
                        b_reg <= b_reg >> skip;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ostream_msg = result;

endmodule

// File: tb/tb_imul_var_lat_param.sv
// Scoreboard bench for imul_var_lat_param: directed product/latency cases plus random traffic.
// Latency: expected output cycle is recorded per request and checked on the first valid cycle.
// Backpressure: consumer ready is randomised, with a forced hold window for stability checks.
module tb_imul_var_lat_param;

    localparam int N  = 32;
    localparam int MS = 8;

    typedef struct {
        logic [N-1:0] res;
        int           vcyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             istream_val = 1'b0;
    logic             istream_rdy;
    logic [2*N+1:0]   istream_msg = '0;
    logic             ostream_val;
    logic             ostream_rdy = 1'b0;
    logic [N-1:0]     ostream_msg;

    exp_t  sb_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    hold = 1'b0;

    bit           seen = 1'b0;
    bit           pv = 1'b0;
    bit           pr = 1'b0;
    logic [N-1:0] pm = '0;

    imul_var_lat_param #(.NBITS(N), .MAX_SKIP(MS)) dut (
        .clk         (clk),
        .reset       (reset),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .istream_msg (istream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .ostream_msg (ostream_msg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: full-width product of (sign-)extended operands, then pick a half
    function automatic logic [N-1:0] ref_mul(input bit sgn, input bit hi,
                                             input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] ea;
        logic [2*N-1:0] eb;
        logic [2*N-1:0] p;
        ea = {{N{sgn & a[N-1]}}, a};
        eb = {{N{sgn & b[N-1]}}, b};
        p  = ea * eb;
        return hi ? p[2*N-1:N] : p[N-1:0];
    endfunction

    // Reference latency: one step per set bit of |b| plus ceil(run/MS) steps per zero run below it
    function automatic int ref_lat(input bit sgn, input logic [N-1:0] b);
        logic [N-1:0] m;
        int k;
        int run;
        m   = (sgn && b[N-1]) ? -b : b;
        k   = 0;
        run = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                k   = k + 1 + (run + MS - 1) / MS;
                run = 0;
            end else begin
                run++;
            end
        end
        return 2 + k;
    endfunction

    task automatic send(input bit sgn, input bit hi, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] exp_res, input int exp_lat);
        int   w;
        exp_t e;
        istream_msg = {sgn, hi, a, b};
        istream_val = 1'b1;
        w = 0;
        @(negedge clk);
        while (!istream_rdy && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!istream_rdy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: istream_rdy got 0 expected 1");
            istream_val = 1'b0;
        end else begin
            e.res  = exp_res;
            e.vcyc = cyc + exp_lat;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
            istream_val = 1'b0;
            istream_msg = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic send_rand(input bit sgn, input bit hi, input logic [N-1:0] a, input logic [N-1:0] b);
        send(sgn, hi, a, b, ref_mul(sgn, hi, a, b), ref_lat(sgn, b));
    endtask

    // Consumer ready: random unless a hold window is requested
    initial begin
        forever begin
            @(posedge clk);
            #1;
            ostream_rdy = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: latency on first valid, stability under backpressure, result on handshake
    always @(negedge clk) begin
        if (reset) begin
            seen = 1'b0;
            pv   = 1'b0;
        end else begin
            if (pv && !pr && ostream_val) chk("msg_stable", 64'(ostream_msg), 64'(pm));
            if (ostream_val && !seen) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_output: got %0h expected no output", ostream_msg);
                end else begin
                    chk("latency", 64'(cyc), 64'(sb_q[0].vcyc));
                end
                seen = 1'b1;
            end
            if (ostream_val && ostream_rdy) begin
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("result", 64'(ostream_msg), 64'(e.res));
                end
                seen = 1'b0;
            end
            pv = ostream_val;
            pr = ostream_rdy;
            pm = ostream_msg;
        end
    end

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int           w;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_istream_rdy", 64'(istream_rdy), 64'd1);
        chk("rst_ostream_val", 64'(ostream_val), 64'd0);
        chk("rst_ostream_msg", 64'(ostream_msg), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases with hand-derived results and latencies
        send(0, 0, 32'd7,        32'd6,        32'h0000002A, 5);
        send(1, 0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 5);
        send(1, 0, 32'd5,        32'hFFFFFFFD, 32'hFFFFFFF1, 4);
        send(0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        send(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34);
        send(1, 1, 32'h80000000, 32'h80000000, 32'h40000000, 7);
        send(1, 1, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 3);
        send(0, 0, 32'd3,        32'h80000000, 32'h80000000, 7);

        // Hold ostream_rdy low on a b==0 result: message stable, no new accept
        w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        hold = 1'b1;
        @(posedge clk);
        #1;
        send(0, 0, 32'h12345678, 32'd0, 32'd0, 2);
        w = 0;
        @(negedge clk);
        while (!ostream_val && w < 50) begin
            @(negedge clk);
            w++;
        end
        istream_val = 1'b1;
        istream_msg = {2'b00, 32'd9, 32'd9};
        for (int i = 0; i < 5; i++) begin
            chk("hold_istream_rdy", 64'(istream_rdy), 64'd0);
            chk("hold_ostream_val", 64'(ostream_val), 64'd1);
            chk("hold_ostream_msg", 64'(ostream_msg), 64'd0);
            @(negedge clk);
        end
        istream_val = 1'b0;
        hold = 1'b0;

        // Reset during a long CALC aborts the transaction
        w = 0;
        while (sb_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        send(0, 0, 32'h0000BEEF, 32'hFFFFFFFF, 32'h0, 34);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_ostream_val", 64'(ostream_val), 64'd0);
        chk("abort_istream_rdy", 64'(istream_rdy), 64'd1);
        @(posedge clk);
        #1;
        send(0, 0, 32'd2, 32'd3, 32'd6, 4);

        // Random traffic: dense, sparse and small multipliers, all modes
        for (int t = 0; t < 200; t++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom & $urandom & $urandom;
                2:       rb = N'($urandom_range(0, 15)) << $urandom_range(0, 28);
                default: rb = -N'($urandom_range(0, 8));
            endcase
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send_rand(1'($urandom), 1'($urandom), ra, rb);
        end

        w = 0;
        while (sb_q.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding expected 0", sb_q.size());
        end
        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
